// File: rtl/queue_pkg.sv
// Shared helpers for queue-based storage cores (ROB / LSQ wrappers).
package queue_pkg;

   // Number of entries for a given index width.
   function automatic int unsigned depth_of(input int unsigned addr_bits);
      return 32'd1 << addr_bits;
   endfunction

   // Slot idx holds a live entry when its distance from head, taken modulo
   // DEPTH, is below the occupancy count.
   function automatic logic is_occupied(input int unsigned idx,
                                        input int unsigned head,
                                        input int unsigned count,
                                        input int unsigned addr_bits);
      int unsigned mask;
      mask = depth_of(addr_bits) - 32'd1;
      return ((idx - head) & mask) < count;
   endfunction

endpackage

// File: rtl/queue_ram.sv
// DEPTH x DATA_BITS storage with push and update write ports and two
// asynchronous read ports. Contents are not reset.
module queue_ram
   import queue_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 i_push_en,
   input  logic [ADDR_BITS-1:0] i_push_idx,
   input  logic [DATA_BITS-1:0] i_push_data,
   input  logic                 i_upd_en,
   input  logic [ADDR_BITS-1:0] i_upd_idx,
   input  logic [DATA_BITS-1:0] i_upd_data,
   input  logic [ADDR_BITS-1:0] i_rd_a_idx,
   output logic [DATA_BITS-1:0] o_rd_a_data,
   input  logic [ADDR_BITS-1:0] i_rd_b_idx,
   output logic [DATA_BITS-1:0] o_rd_b_data
);

   localparam int unsigned DEPTH = depth_of(ADDR_BITS);

   logic [DATA_BITS-1:0] r_mem [DEPTH];

   // Both write ports; the controller guarantees they never hit the same slot.
   always_ff @(posedge clk) begin
      if (i_upd_en)  r_mem[i_upd_idx]  <= i_upd_data;
      if (i_push_en) r_mem[i_push_idx] <= i_push_data;
   end

   // Asynchronous reads show pre-edge contents (no write bypass).
   always_comb begin
      o_rd_a_data = r_mem[i_rd_a_idx];
      o_rd_b_data = r_mem[i_rd_b_idx];
   end

endmodule

// File: rtl/ra_queue.sv
// Circular FIFO with random read/update by slot index, flush, occupancy
// count and head/tail index reporting.
module ra_queue
   import queue_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic [DATA_BITS-1:0] rd_data,
   output logic [ADDR_BITS-1:0] rd_idx,
   output logic [ADDR_BITS-1:0] wr_idx,
   input  logic [ADDR_BITS-1:0] ra_rd_idx,
   output logic [DATA_BITS-1:0] ra_rd_data,
   output logic                 ra_rd_valid,
   input  logic                 ra_wr_en,
   input  logic [ADDR_BITS-1:0] ra_wr_idx,
   input  logic [DATA_BITS-1:0] ra_wr_data,
   output logic [ADDR_BITS:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned DEPTH = depth_of(ADDR_BITS);
   localparam int unsigned CW    = ADDR_BITS + 1;

   logic [ADDR_BITS-1:0] r_head;
   logic [ADDR_BITS-1:0] r_tail;
   logic [CW-1:0]        r_count;
   logic                 r_full;
   logic                 r_empty;

   logic                 w_pop_ok;
   logic                 w_push_ok;
   logic                 w_upd_ok;
   logic                 w_kill;
   logic [ADDR_BITS-1:0] w_head_nxt;
   logic [ADDR_BITS-1:0] w_tail_nxt;
   logic [CW-1:0]        w_count_nxt;

   // Protected enables from registered flags; flush/reset discard everything.
   always_comb begin
      w_kill    = reset | flush;
      w_pop_ok  = rd_en & ~r_empty & ~w_kill;
      w_push_ok = wr_en & ~r_full  & ~w_kill;
      w_upd_ok  = ra_wr_en & ~w_kill &
                  is_occupied(32'(ra_wr_idx), 32'(r_head), 32'(r_count), ADDR_BITS);
   end

   // Next pointer and count values.
   always_comb begin
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      if (w_kill) begin
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_count_nxt = '0;
      end else begin
         if (w_pop_ok)  w_head_nxt = r_head + ADDR_BITS'(1);
         if (w_push_ok) w_tail_nxt = r_tail + ADDR_BITS'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Pointer, count and flag registers; flags are precomputed from next count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   queue_ram #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk         (clk),
      .i_push_en   (w_push_ok),
      .i_push_idx  (r_tail),
      .i_push_data (wr_data),
      .i_upd_en    (w_upd_ok),
      .i_upd_idx   (ra_wr_idx),
      .i_upd_data  (ra_wr_data),
      .i_rd_a_idx  (r_head),
      .o_rd_a_data (rd_data),
      .i_rd_b_idx  (ra_rd_idx),
      .o_rd_b_data (ra_rd_data)
   );

   // Output mapping and random-read occupancy.
   always_comb begin
      rd_idx      = r_head;
      wr_idx      = r_tail;
      count       = r_count;
      full        = r_full;
      empty       = r_empty;
      ra_rd_valid = is_occupied(32'(ra_rd_idx), 32'(r_head), 32'(r_count), ADDR_BITS);
   end

endmodule

// File: tb/tb_ra_queue.sv
// Self-checking bench for ra_queue: directed scenarios plus random traffic,
// checked every cycle against a slot-array/head/count model.
module tb_ra_queue;

   logic       clk = 1'b0;
   logic       reset, flush, rd_en, wr_en, ra_wr_en;
   logic [7:0] wr_data, ra_wr_data, rd_data, ra_rd_data;
   logic [2:0] rd_idx, wr_idx, ra_rd_idx, ra_wr_idx;
   logic       ra_rd_valid, full, empty;
   logic [3:0] count;

   int checks   = 0;
   int failures = 0;

   int m_mem [8];
   int m_head  = 0;
   int m_count = 0;

   always #5 clk = ~clk;

   ra_queue #(.DATA_BITS(8), .ADDR_BITS(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .rd_en(rd_en), .wr_en(wr_en),
      .wr_data(wr_data), .rd_data(rd_data), .rd_idx(rd_idx), .wr_idx(wr_idx),
      .ra_rd_idx(ra_rd_idx), .ra_rd_data(ra_rd_data), .ra_rd_valid(ra_rd_valid),
      .ra_wr_en(ra_wr_en), .ra_wr_idx(ra_wr_idx), .ra_wr_data(ra_wr_data),
      .count(count), .full(full), .empty(empty)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic bit m_occ(input int idx);
      for (int i = 0; i < m_count; i++)
         if ((m_head + i) % 8 == idx) return 1'b1;
      return 1'b0;
   endfunction

   // Apply the queue rules to the model using the inputs present at the edge.
   task automatic model_edge();
      bit pop, push, upd;
      if (reset || flush) begin
         m_head  = 0;
         m_count = 0;
      end else begin
         pop  = rd_en && (m_count > 0);
         push = wr_en && (m_count < 8);
         upd  = ra_wr_en && m_occ(int'(ra_wr_idx));
         if (upd)  m_mem[ra_wr_idx] = int'(ra_wr_data);
         if (push) m_mem[(m_head + m_count) % 8] = int'(wr_data);
         if (pop)  m_head = (m_head + 1) % 8;
         m_count = m_count + int'(push) - int'(pop);
      end
   endtask

   task automatic compare_model();
      chk("m_rd_idx", int'(rd_idx), m_head);
      chk("m_wr_idx", int'(wr_idx), (m_head + m_count) % 8);
      chk("m_count",  int'(count), m_count);
      chk("m_full",   int'(full),  int'(m_count == 8));
      chk("m_empty",  int'(empty), int'(m_count == 0));
      chk("m_ra_valid", int'(ra_rd_valid), int'(m_occ(int'(ra_rd_idx))));
      if (m_count > 0) chk("m_rd_data", int'(rd_data), m_mem[m_head]);
      if (m_occ(int'(ra_rd_idx))) chk("m_ra_data", int'(ra_rd_data), m_mem[ra_rd_idx]);
   endtask

   task automatic idle();
      reset = 0; flush = 0; rd_en = 0; wr_en = 0; ra_wr_en = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
      idle();
   endtask

   task automatic push(input int d);
      wr_en = 1; wr_data = 8'(d); tick();
   endtask

   task automatic pop();
      rd_en = 1; tick();
   endtask

   int sv_rd, sv_wr;

   initial begin
      idle();
      reset = 1; wr_data = '0; ra_wr_idx = '0; ra_wr_data = '0; ra_rd_idx = '0;
      @(negedge clk);
      reset = 1; tick();
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_idx", int'({rd_idx, wr_idx}), 0);
      chk("rst_ra_valid", int'(ra_rd_valid), 0);

      // Fill to full, then an overflowing push.
      for (int i = 0; i < 8; i++) begin
         chk("fill_wr_idx", int'(wr_idx), i);
         push(17 * (i + 1));
      end
      chk("full_wr_idx", int'(wr_idx), 0);
      chk("full_flag", int'(full), 1);
      chk("full_count", int'(count), 8);
      push(8'h99);
      chk("ovf_count", int'(count), 8);
      chk("ovf_rd_data", int'(rd_data), 8'h11);

      // Drain in order, then an underflowing pop.
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", int'(rd_data), 17 * (i + 1));
         pop();
      end
      chk("drain_empty", int'(empty), 1);
      pop();
      chk("udf_rd_idx", int'(rd_idx), 0);

      // Wrap-around placement.
      for (int i = 0; i < 5; i++) push(i);
      for (int i = 0; i < 5; i++) pop();
      for (int i = 0; i < 6; i++) push(8'hA0 + i);
      ra_rd_idx = 3'd1; #1;
      chk("wrap_valid1", int'(ra_rd_valid), 1);
      chk("wrap_data1", int'(ra_rd_data), 8'hA4);
      ra_rd_idx = 3'd4; #1;
      chk("wrap_valid4", int'(ra_rd_valid), 0);

      // Random update: no bypass, visible next cycle.
      ra_rd_idx = 3'd7; ra_wr_en = 1; ra_wr_idx = 3'd7; ra_wr_data = 8'hAB; #1;
      chk("upd_same_cycle", int'(ra_rd_data), 8'hA2);
      tick();
      chk("upd_next_cycle", int'(ra_rd_data), 8'hAB);
      ra_wr_en = 1; ra_wr_idx = 3'd3; ra_wr_data = 8'hFF; tick();
      push(8'h5A);
      ra_rd_idx = 3'd3; #1;
      chk("upd_ignored", int'(ra_rd_data), 8'h5A);

      // Simultaneous push/pop at full, empty and mid occupancy.
      push(8'h77);
      chk("pp_full_pre", int'(count), 8);
      wr_en = 1; rd_en = 1; wr_data = 8'h66; tick();
      chk("pp_full", int'(count), 7);
      flush = 1; tick();
      wr_en = 1; rd_en = 1; wr_data = 8'h3C; tick();
      chk("pp_empty_cnt", int'(count), 1);
      chk("pp_empty_data", int'(rd_data), 8'h3C);
      for (int i = 0; i < 3; i++) push(8'h40 + i);
      sv_rd = int'(rd_idx); sv_wr = int'(wr_idx);
      wr_en = 1; rd_en = 1; wr_data = 8'h4F; tick();
      chk("pp_mid_cnt", int'(count), 4);
      chk("pp_mid_rd", int'(rd_idx), (sv_rd + 1) % 8);
      chk("pp_mid_wr", int'(wr_idx), (sv_wr + 1) % 8);

      // Flush, then reset, with every other input active.
      push(8'h50);
      chk("fl_pre", int'(count), 5);
      flush = 1; wr_en = 1; rd_en = 1; ra_wr_en = 1; ra_wr_idx = rd_idx; tick();
      chk("fl_count", int'(count), 0);
      chk("fl_empty", int'(empty), 1);
      chk("fl_idx", int'({rd_idx, wr_idx}), 0);
      for (int i = 0; i < 5; i++) push(8'h60 + i);
      reset = 1; wr_en = 1; rd_en = 1; ra_wr_en = 1; ra_wr_idx = 3'd2; tick();
      chk("rs_count", int'(count), 0);
      chk("rs_empty", int'(empty), 1);
      chk("rs_idx", int'({rd_idx, wr_idx}), 0);

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         wr_en      = ($urandom_range(99) < 55);
         rd_en      = ($urandom_range(99) < 45);
         wr_data    = 8'($urandom);
         ra_wr_en   = ($urandom_range(99) < 40);
         ra_wr_idx  = 3'($urandom);
         ra_wr_data = 8'($urandom);
         ra_rd_idx  = 3'($urandom);
         flush      = ($urandom_range(59) == 0);
         reset      = ($urandom_range(199) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
